// File: rtl/game_ctrl.sv
// Game-flow FSM (cover/ready/game/pause/over) plus keyboard action decoding:
// held-key tracking, last-pressed-wins direction level, and typematic-safe jump pulse.
module game_ctrl #(
  parameter logic [8:0]  KEY_LEFT  = 9'h01C,
  parameter logic [8:0]  KEY_RIGHT = 9'h023,
  parameter logic [8:0]  KEY_JUMP  = 9'h029,
  parameter logic [8:0]  KEY_START = 9'h05A,
  parameter logic [8:0]  KEY_PAUSE = 9'h076,
  parameter int unsigned COUNTDOWN = 3,
  parameter int unsigned OVER_HOLD = 120,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             key_valid_i,
  input  logic [8:0]       key_code_i,
  input  logic             key_make_i,
  input  logic             tick_i,
  input  logic             slime_die_i,
  output logic [2:0]       state_o,
  output logic [1:0]       dir_o,
  output logic             jump_pulse_o,
  output logic             game_rst_o,
  output logic             freeze_o,
  output logic [CNT_W-1:0] count_o
);

  typedef enum logic [2:0] {
    COVER = 3'd0, READY = 3'd1, GAME = 3'd2, PAUSE = 3'd3, OVER = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             held_l_q, held_l_d, held_r_q, held_r_d, held_j_q, held_j_d;
  logic             last_r_q, last_r_d;
  logic [1:0]       dir_q, dir_d;
  logic             jump_q, jump_d, grst_q, grst_d, freeze_q, freeze_d;

  logic mk, br, is_l, is_r, is_j, is_s, is_p, track;

  always_comb begin
    mk   = key_valid_i & key_make_i;
    br   = key_valid_i & ~key_make_i;
    is_l = (key_code_i == KEY_LEFT);
    is_r = (key_code_i == KEY_RIGHT);
    is_j = (key_code_i == KEY_JUMP);
    is_s = (key_code_i[7:0] == KEY_START[7:0]);
    is_p = (key_code_i == KEY_PAUSE);
    track = (state_q == READY) || (state_q == GAME) || (state_q == PAUSE);

    state_d  = state_q;
    cnt_d    = cnt_q;
    held_l_d = held_l_q;
    held_r_d = held_r_q;
    held_j_d = held_j_q;
    last_r_d = last_r_q;
    jump_d   = 1'b0;
    grst_d   = 1'b0;

    // last_r remembers which direction key was pressed most recently
    if (track) begin
      if (mk && is_l) begin held_l_d = 1'b1; last_r_d = 1'b0; end
      if (br && is_l) held_l_d = 1'b0;
      if (mk && is_r) begin held_r_d = 1'b1; last_r_d = 1'b1; end
      if (br && is_r) held_r_d = 1'b0;
      if (mk && is_j) held_j_d = 1'b1;
      if (br && is_j) held_j_d = 1'b0;
    end

    case (state_q)
      COVER: if (mk && is_s) begin
        state_d = READY;
        cnt_d   = CNT_W'(COUNTDOWN);
        grst_d  = 1'b1;
      end
      READY: begin
        if (cnt_q == '0) state_d = GAME;
        else if (tick_i) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = GAME;
        end
      end
      GAME: begin
        jump_d = mk & is_j & ~held_j_q;
        if (slime_die_i) begin
          state_d = OVER;
          cnt_d   = CNT_W'(OVER_HOLD);
        end else if (mk && is_p) state_d = PAUSE;
      end
      PAUSE: if (mk && (is_p || is_s)) state_d = GAME;
      OVER: begin
        if (cnt_q == '0) state_d = COVER;
        else if (tick_i) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = COVER;
        end
      end
      default: begin
        state_d = COVER;
        cnt_d   = '0;
      end
    endcase

    if (state_d == COVER || state_d == OVER) begin
      held_l_d = 1'b0;
      held_r_d = 1'b0;
      held_j_d = 1'b0;
    end

    dir_d = 2'b00;
    if (state_d == GAME) begin
      if (held_l_d && held_r_d) dir_d = last_r_d ? 2'b01 : 2'b10;
      else if (held_l_d)        dir_d = 2'b10;
      else if (held_r_d)        dir_d = 2'b01;
    end
    freeze_d = (state_d != GAME);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= COVER;
      cnt_q    <= '0;
      held_l_q <= 1'b0;
      held_r_q <= 1'b0;
      held_j_q <= 1'b0;
      last_r_q <= 1'b0;
      dir_q    <= 2'b00;
      jump_q   <= 1'b0;
      grst_q   <= 1'b0;
      freeze_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      held_l_q <= held_l_d;
      held_r_q <= held_r_d;
      held_j_q <= held_j_d;
      last_r_q <= last_r_d;
      dir_q    <= dir_d;
      jump_q   <= jump_d;
      grst_q   <= grst_d;
      freeze_q <= freeze_d;
    end
  end

  assign state_o      = state_q;
  assign dir_o        = dir_q;
  assign jump_pulse_o = jump_q;
  assign game_rst_o   = grst_q;
  assign freeze_o     = freeze_q;
  assign count_o      = cnt_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: a timestamp-based reference model predicts each
// cycle's outputs for two builds (default, and COUNTDOWN=0/OVER_HOLD=0).
module tb_game_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, kv, km, tick, die;
  logic [8:0] kc;

  logic [2:0] a_st, b_st;
  logic [1:0] a_dir, b_dir;
  logic       a_jp, b_jp, a_gr, b_gr, a_fz, b_fz;
  logic [7:0] a_cnt;
  logic [3:0] b_cnt;

  game_ctrl dut (
    .clk_i(clk), .rst_i(rst), .key_valid_i(kv), .key_code_i(kc), .key_make_i(km),
    .tick_i(tick), .slime_die_i(die), .state_o(a_st), .dir_o(a_dir),
    .jump_pulse_o(a_jp), .game_rst_o(a_gr), .freeze_o(a_fz), .count_o(a_cnt));

  game_ctrl #(.COUNTDOWN(0), .OVER_HOLD(0), .CNT_W(4)) dut0 (
    .clk_i(clk), .rst_i(rst), .key_valid_i(kv), .key_code_i(kc), .key_make_i(km),
    .tick_i(tick), .slime_die_i(die), .state_o(b_st), .dir_o(b_dir),
    .jump_pulse_o(b_jp), .game_rst_o(b_gr), .freeze_o(b_fz), .count_o(b_cnt));

  typedef struct packed {
    logic [2:0] st; logic [1:0] dir; logic jp; logic gr; logic fz; logic [7:0] cnt;
  } obs_t;

  // Model: press timestamps instead of flags; 0 means "not held".
  typedef struct packed {
    int st; int cnt; int tl; int tr; int cyc; bit hj; bit jp; bit gr;
  } mdl_t;

  obs_t q_a[$], q_b[$];
  mdl_t ma, mb;
  int   n_tests = 0, n_fail = 0;
  logic [8:0] codes [8] = '{9'h01C, 9'h023, 9'h029, 9'h05A, 9'h15A, 9'h076, 9'h11C, 9'h0AB};

  function automatic mdl_t step(mdl_t m, logic r, logic v, logic [8:0] c, logic k,
                                logic t, logic d, int cd, int hold);
    mdl_t n = m;
    bit mk = v & k, br = v & ~k;
    bit kl = (c == 9'h01C), kr = (c == 9'h023), kj = (c == 9'h029);
    bit kp = (c == 9'h076), ks = (c[7:0] == 8'h5A);
    if (!r) begin n = '0; return n; end
    n.cyc = m.cyc + 1; n.jp = 0; n.gr = 0;
    if (m.st >= 1 && m.st <= 3) begin
      if (mk && kl) n.tl = n.cyc;
      if (br && kl) n.tl = 0;
      if (mk && kr) n.tr = n.cyc;
      if (br && kr) n.tr = 0;
      if (m.st == 2 && mk && kj && !m.hj) n.jp = 1;
      if (mk && kj) n.hj = 1;
      if (br && kj) n.hj = 0;
    end
    case (m.st)
      0: if (mk && ks) begin n.st = 1; n.cnt = cd; n.gr = 1; end
      1: if (m.cnt == 0) n.st = 2;
         else if (t) begin n.cnt = m.cnt - 1; if (n.cnt == 0) n.st = 2; end
      2: if (d) begin n.st = 4; n.cnt = hold; end
         else if (mk && kp) n.st = 3;
      3: if (mk && (kp || ks)) n.st = 2;
      default: if (m.cnt == 0) n.st = 0;
         else if (t) begin n.cnt = m.cnt - 1; if (n.cnt == 0) n.st = 0; end
    endcase
    if (n.st == 0 || n.st == 4) begin n.tl = 0; n.tr = 0; n.hj = 0; end
    return n;
  endfunction

  function automatic obs_t view(mdl_t m);
    obs_t o;
    o.st  = m.st[2:0];
    o.cnt = m.cnt[7:0];
    o.jp  = m.jp;
    o.gr  = m.gr;
    o.fz  = (m.st != 2);
    o.dir = 2'b00;
    if (m.st == 2) begin
      if (m.tl != 0 && m.tr != 0) o.dir = (m.tl > m.tr) ? 2'b10 : 2'b01;
      else if (m.tl != 0)         o.dir = 2'b10;
      else if (m.tr != 0)         o.dir = 2'b01;
    end
    return o;
  endfunction

  task automatic drv(logic r, logic v, logic [8:0] c, logic k, logic t, logic d);
    @(negedge clk);
    rst = r; kv = v; kc = c; km = k; tick = t; die = d;
    ma = step(ma, r, v, c, k, t, d, 3, 120);
    mb = step(mb, r, v, c, k, t, d, 0, 0);
    q_a.push_back(view(ma));
    q_b.push_back(view(mb));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drv(1, 0, 9'h000, 0, 0, 0);
  endtask
  task automatic key(logic [8:0] c, logic k);
    drv(1, 1, c, k, 0, 0);
  endtask
  task automatic ticks(int n);
    for (int i = 0; i < n; i++) drv(1, 0, 9'h000, 0, 1, 0);
  endtask

  task automatic cmp(string nm, obs_t act, obs_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got st=%0d dir=%b jp=%b gr=%b fz=%b cnt=%0d, want st=%0d dir=%b jp=%b gr=%b fz=%b cnt=%0d",
               nm, $time, act.st, act.dir, act.jp, act.gr, act.fz, act.cnt,
               exp.st, exp.dir, exp.jp, exp.gr, exp.fz, exp.cnt);
    end
  endtask

  // Monitor: one observation per clock, decoupled from the driver.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q_a.size() > 0) cmp("dut", {a_st, a_dir, a_jp, a_gr, a_fz, a_cnt}, q_a.pop_front());
      if (q_b.size() > 0) cmp("dut0", {b_st, b_dir, b_jp, b_gr, b_fz, {4'b0, b_cnt}}, q_b.pop_front());
    end
  end

  initial begin
    rst = 0; kv = 0; kc = '0; km = 0; tick = 0; die = 0;
    ma = '0; mb = '0;
    drv(0, 0, 9'h000, 0, 0, 0);
    drv(0, 1, 9'h05A, 1, 1, 0);
    idle(2);
    key(9'h15A, 1); idle(2); ticks(3); idle(1);
    key(9'h01C, 1); key(9'h023, 1); key(9'h023, 0); key(9'h01C, 0);
    key(9'h029, 1); key(9'h029, 1); key(9'h029, 1); key(9'h029, 0); key(9'h029, 1); key(9'h029, 0);
    drv(1, 1, 9'h076, 1, 0, 1);
    key(9'h05A, 1); ticks(60); key(9'h15A, 1); ticks(60); idle(2);
    key(9'h05A, 1); ticks(3); key(9'h01C, 1);
    key(9'h076, 1); drv(1, 0, 9'h000, 0, 0, 1); key(9'h076, 1); key(9'h01C, 0);
    drv(1, 0, 9'h000, 0, 0, 1); idle(1); ticks(120);
    key(9'h05A, 1); ticks(1); drv(0, 0, 9'h000, 0, 1, 0); idle(2);
    for (int i = 0; i < 20000; i++)
      drv($urandom_range(0, 499) != 0, ($urandom % 3) == 0, codes[$urandom % 8],
          ($urandom % 10) < 7, ($urandom % 4) == 0, ($urandom % 60) == 0);
    idle(1);
    @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
